// File: rtl/c_cache_data_stage.sv
// C stage of the pipeline: 4-way data array, load-data selection, miss refill
// FSM against memory, store-buffer drain merging, and the registered C->WB slot.
module c_cache_data_stage (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         kill_i,
  input  logic         c_valid_i,
  input  logic         c_mem_read_i,
  input  logic [19:0]  c_addr_i,
  input  logic         c_rqst_byte_i,
  input  logic [1:0]   c_hit_way_i,
  input  logic [1:0]   c_lru_way_i,
  input  logic         c_miss_i,
  input  logic         c_buffer_hit_i,
  input  logic [31:0]  c_buffer_data_i,
  input  logic         c_int_write_enable_i,
  input  logic [4:0]   c_write_addr_i,
  input  logic [31:0]  c_pc_i,
  input  logic         sb_drain_valid_i,
  input  logic [19:0]  sb_drain_addr_i,
  input  logic [31:0]  sb_drain_data_i,
  input  logic         sb_drain_byte_i,
  input  logic [1:0]   sb_drain_way_i,
  input  logic         sb_drain_hit_i,
  output logic         sb_drain_ready_o,
  output logic         mem_rd_req_o,
  output logic [19:0]  mem_addr_o,
  input  logic         mem_ack_i,
  input  logic [127:0] mem_data_i,
  output logic         fill_valid_o,
  output logic [1:0]   fill_way_o,
  output logic [19:0]  fill_addr_o,
  output logic         stall_core_o,
  output logic         wb_valid_o,
  output logic [31:0]  wb_data_o,
  output logic         wb_int_write_enable_o,
  output logic [4:0]   wb_write_addr_o,
  output logic [31:0]  wb_pc_o
);

  localparam int unsigned ADDR_W = 20;
  localparam int unsigned WAYS   = 4;
  localparam int unsigned SETS   = 4;
  localparam int unsigned LINE_W = 128;
  localparam int unsigned WORD_W = 32;
  localparam int unsigned LINES  = WAYS * SETS;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_FILL = 2'd2;

  // Data array, indexed {way, set}; contents are not reset (valid bits live in TL).
  logic [LINE_W-1:0] data_q [LINES];

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] addr_q, addr_d;
  logic [1:0]        way_q, way_d;
  logic              byte_q, byte_d;
  logic              we_q, we_d;
  logic [4:0]        wa_q, wa_d;
  logic [31:0]       pc_q, pc_d;
  logic              killed_q, killed_d;

  logic              mem_rd_req_q, mem_rd_req_d;
  logic [ADDR_W-1:0] mem_addr_q, mem_addr_d;
  logic              fill_valid_q, fill_valid_d;
  logic [1:0]        fill_way_q, fill_way_d;
  logic [ADDR_W-1:0] fill_addr_q, fill_addr_d;

  logic              wb_valid_q, wb_valid_d;
  logic [WORD_W-1:0] wb_data_q, wb_data_d;
  logic              wb_we_q, wb_we_d;
  logic [4:0]        wb_wa_q, wb_wa_d;
  logic [31:0]       wb_pc_q, wb_pc_d;

  logic              arr_we_c;
  logic [3:0]        arr_idx_c;
  logic [LINE_W-1:0] arr_line_c;
  logic              raw_miss_c;
  logic              stall_c;
  logic              drain_ready_c;
  logic              unused_drain_tag_c;

  // Tag bits of the drain address are already resolved by the store buffer.
  assign unused_drain_tag_c = ^sb_drain_addr_i[19:6];

  // Word at off_w of a line, optionally narrowed to a zero-extended byte.
  function automatic logic [WORD_W-1:0] pick_load(input logic [LINE_W-1:0] line,
                                                  input logic [1:0] off_w,
                                                  input logic [1:0] off_b,
                                                  input logic is_byte);
    logic [WORD_W-1:0] word;
    word = line[{off_w, 5'd0} +: WORD_W];
    if (is_byte) begin
      return {24'd0, word[{off_b, 3'd0} +: 8]};
    end
    return word;
  endfunction

  // Merge a drained word or byte into a line.
  function automatic logic [LINE_W-1:0] merge_store(input logic [LINE_W-1:0] line,
                                                    input logic [3:0] off,
                                                    input logic [WORD_W-1:0] data,
                                                    input logic is_byte);
    logic [LINE_W-1:0] res;
    res = line;
    if (is_byte) begin
      res[{off, 3'd0} +: 8] = data[7:0];
    end else begin
      res[{off[3:2], 5'd0} +: WORD_W] = data;
    end
    return res;
  endfunction

  assign raw_miss_c = c_valid_i & c_mem_read_i & c_miss_i & ~c_buffer_hit_i;

  // Next-state, array write port and WB slot selection.
  always_comb begin
    state_d      = state_q;
    addr_d       = addr_q;
    way_d        = way_q;
    byte_d       = byte_q;
    we_d         = we_q;
    wa_d         = wa_q;
    pc_d         = pc_q;
    killed_d     = killed_q;
    mem_rd_req_d = mem_rd_req_q;
    mem_addr_d   = mem_addr_q;
    fill_valid_d = 1'b0;
    fill_way_d   = fill_way_q;
    fill_addr_d  = fill_addr_q;
    wb_valid_d   = 1'b0;
    wb_data_d    = '0;
    wb_we_d      = 1'b0;
    wb_wa_d      = '0;
    wb_pc_d      = '0;
    arr_we_c     = 1'b0;
    arr_idx_c    = '0;
    arr_line_c   = '0;
    stall_c      = 1'b0;
    drain_ready_c = 1'b0;

    case (state_q)
      S_IDLE: begin
        drain_ready_c = sb_drain_valid_i & ~raw_miss_c;
        if (drain_ready_c && sb_drain_hit_i) begin
          arr_we_c   = 1'b1;
          arr_idx_c  = {sb_drain_way_i, sb_drain_addr_i[5:4]};
          arr_line_c = merge_store(data_q[{sb_drain_way_i, sb_drain_addr_i[5:4]}],
                                   sb_drain_addr_i[3:0], sb_drain_data_i, sb_drain_byte_i);
        end
        if (raw_miss_c && !kill_i) begin
          stall_c      = 1'b1;
          state_d      = S_REQ;
          addr_d       = c_addr_i;
          way_d        = c_lru_way_i;
          byte_d       = c_rqst_byte_i;
          we_d         = c_int_write_enable_i;
          wa_d         = c_write_addr_i;
          pc_d         = c_pc_i;
          killed_d     = 1'b0;
          mem_rd_req_d = 1'b1;
          mem_addr_d   = {c_addr_i[19:4], 4'd0};
        end else if (c_valid_i && !kill_i && !raw_miss_c) begin
          wb_valid_d = 1'b1;
          wb_we_d    = c_int_write_enable_i;
          wb_wa_d    = c_write_addr_i;
          wb_pc_d    = c_pc_i;
          if (c_mem_read_i) begin
            wb_data_d = c_buffer_hit_i ? c_buffer_data_i
                      : pick_load(data_q[{c_hit_way_i, c_addr_i[5:4]}],
                                  c_addr_i[3:2], c_addr_i[1:0], c_rqst_byte_i);
          end
        end
      end
      S_REQ: begin
        stall_c = 1'b1;
        if (kill_i) begin
          killed_d = 1'b1;
        end
        if (mem_ack_i) begin
          arr_we_c     = 1'b1;
          arr_idx_c    = {way_q, addr_q[5:4]};
          arr_line_c   = mem_data_i;
          state_d      = S_FILL;
          mem_rd_req_d = 1'b0;
          mem_addr_d   = '0;
          fill_valid_d = 1'b1;
          fill_way_d   = way_q;
          fill_addr_d  = {addr_q[19:4], 4'd0};
        end
      end
      S_FILL: begin
        state_d = S_IDLE;
        if (!killed_q && !kill_i) begin
          wb_valid_d = 1'b1;
          wb_we_d    = we_q;
          wb_wa_d    = wa_q;
          wb_pc_d    = pc_q;
          wb_data_d  = pick_load(data_q[{way_q, addr_q[5:4]}],
                                 addr_q[3:2], addr_q[1:0], byte_q);
        end
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  // State, miss context and output registers.
  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      state_q      <= S_IDLE;
      addr_q       <= '0;
      way_q        <= '0;
      byte_q       <= 1'b0;
      we_q         <= 1'b0;
      wa_q         <= '0;
      pc_q         <= '0;
      killed_q     <= 1'b0;
      mem_rd_req_q <= 1'b0;
      mem_addr_q   <= '0;
      fill_valid_q <= 1'b0;
      fill_way_q   <= '0;
      fill_addr_q  <= '0;
      wb_valid_q   <= 1'b0;
      wb_data_q    <= '0;
      wb_we_q      <= 1'b0;
      wb_wa_q      <= '0;
      wb_pc_q      <= '0;
    end else begin
      state_q      <= state_d;
      addr_q       <= addr_d;
      way_q        <= way_d;
      byte_q       <= byte_d;
      we_q         <= we_d;
      wa_q         <= wa_d;
      pc_q         <= pc_d;
      killed_q     <= killed_d;
      mem_rd_req_q <= mem_rd_req_d;
      mem_addr_q   <= mem_addr_d;
      fill_valid_q <= fill_valid_d;
      fill_way_q   <= fill_way_d;
      fill_addr_q  <= fill_addr_d;
      wb_valid_q   <= wb_valid_d;
      wb_data_q    <= wb_data_d;
      wb_we_q      <= wb_we_d;
      wb_wa_q      <= wb_wa_d;
      wb_pc_q      <= wb_pc_d;
    end
  end

  // Single array write port; a reset cycle writes nothing.
  always_ff @(posedge clk_i) begin
    if (!rst_i && arr_we_c) begin
      data_q[arr_idx_c] <= arr_line_c;
    end
  end

  assign sb_drain_ready_o      = drain_ready_c;
  assign stall_core_o          = stall_c;
  assign mem_rd_req_o          = mem_rd_req_q;
  assign mem_addr_o            = mem_addr_q;
  assign fill_valid_o          = fill_valid_q;
  assign fill_way_o            = fill_way_q;
  assign fill_addr_o           = fill_addr_q;
  assign wb_valid_o            = wb_valid_q;
  assign wb_data_o             = wb_data_q;
  assign wb_int_write_enable_o = wb_we_q;
  assign wb_write_addr_o       = wb_wa_q;
  assign wb_pc_o               = wb_pc_q;

endmodule

// File: tb/tb_c_cache_data_stage.sv
// Scoreboard bench for c_cache_data_stage: stimulus pushes expected WB records,
// a negedge monitor pops and compares whenever wb_valid_o is seen.
module tb_c_cache_data_stage;

  logic         clk_i = 1'b0;
  logic         rst_i;
  logic         kill_i;
  logic         c_valid_i, c_mem_read_i, c_rqst_byte_i, c_miss_i, c_buffer_hit_i;
  logic [19:0]  c_addr_i;
  logic [1:0]   c_hit_way_i, c_lru_way_i;
  logic [31:0]  c_buffer_data_i, c_pc_i;
  logic         c_int_write_enable_i;
  logic [4:0]   c_write_addr_i;
  logic         sb_drain_valid_i, sb_drain_byte_i, sb_drain_hit_i;
  logic [19:0]  sb_drain_addr_i;
  logic [31:0]  sb_drain_data_i;
  logic [1:0]   sb_drain_way_i;
  logic         sb_drain_ready_o;
  logic         mem_rd_req_o;
  logic [19:0]  mem_addr_o;
  logic         mem_ack_i;
  logic [127:0] mem_data_i;
  logic         fill_valid_o;
  logic [1:0]   fill_way_o;
  logic [19:0]  fill_addr_o;
  logic         stall_core_o;
  logic         wb_valid_o;
  logic [31:0]  wb_data_o;
  logic         wb_int_write_enable_o;
  logic [4:0]   wb_write_addr_o;
  logic [31:0]  wb_pc_o;

  typedef struct packed {
    logic [31:0] data;
    logic        we;
    logic [4:0]  wa;
    logic [31:0] pc;
  } wb_t;

  wb_t exp_q[$];
  int  errors = 0;
  int  checks = 0;

  c_cache_data_stage dut (
    .clk_i(clk_i), .rst_i(rst_i), .kill_i(kill_i),
    .c_valid_i(c_valid_i), .c_mem_read_i(c_mem_read_i), .c_addr_i(c_addr_i),
    .c_rqst_byte_i(c_rqst_byte_i), .c_hit_way_i(c_hit_way_i), .c_lru_way_i(c_lru_way_i),
    .c_miss_i(c_miss_i), .c_buffer_hit_i(c_buffer_hit_i), .c_buffer_data_i(c_buffer_data_i),
    .c_int_write_enable_i(c_int_write_enable_i), .c_write_addr_i(c_write_addr_i), .c_pc_i(c_pc_i),
    .sb_drain_valid_i(sb_drain_valid_i), .sb_drain_addr_i(sb_drain_addr_i),
    .sb_drain_data_i(sb_drain_data_i), .sb_drain_byte_i(sb_drain_byte_i),
    .sb_drain_way_i(sb_drain_way_i), .sb_drain_hit_i(sb_drain_hit_i),
    .sb_drain_ready_o(sb_drain_ready_o),
    .mem_rd_req_o(mem_rd_req_o), .mem_addr_o(mem_addr_o), .mem_ack_i(mem_ack_i),
    .mem_data_i(mem_data_i),
    .fill_valid_o(fill_valid_o), .fill_way_o(fill_way_o), .fill_addr_o(fill_addr_o),
    .stall_core_o(stall_core_o),
    .wb_valid_o(wb_valid_o), .wb_data_o(wb_data_o),
    .wb_int_write_enable_o(wb_int_write_enable_o), .wb_write_addr_o(wb_write_addr_o),
    .wb_pc_o(wb_pc_o)
  );

  always #5 clk_i = ~clk_i;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%08h expected 0x%08h", name, act, exp);
    end
  endtask

  // Monitor: every retired WB slot must match the oldest expected record.
  always @(negedge clk_i) begin
    if (!rst_i && wb_valid_o) begin
      if (exp_q.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL wb_unexpected: got data 0x%08h pc 0x%08h with no expected entry", wb_data_o, wb_pc_o);
      end else begin
        wb_t e;
        e = exp_q.pop_front();
        check("wb_data", wb_data_o, e.data);
        check("wb_we", 32'(wb_int_write_enable_o), 32'(e.we));
        check("wb_waddr", 32'(wb_write_addr_o), 32'(e.wa));
        check("wb_pc", wb_pc_o, e.pc);
      end
    end
  end

  task automatic tick();
    @(posedge clk_i);
    #1;
  endtask

  task automatic clear_c();
    c_valid_i = 0; c_mem_read_i = 0; c_rqst_byte_i = 0; c_miss_i = 0;
    c_buffer_hit_i = 0; c_buffer_data_i = '0; c_addr_i = '0; c_hit_way_i = '0;
    c_lru_way_i = '0; c_int_write_enable_i = 0; c_write_addr_i = '0; c_pc_i = '0;
  endtask

  task automatic drive_load(input logic [19:0] addr, input logic is_byte, input logic [1:0] hway,
                            input logic [1:0] lway, input logic miss, input logic bhit,
                            input logic [31:0] bdata, input logic [4:0] wa, input logic [31:0] pc);
    c_valid_i = 1; c_mem_read_i = 1; c_addr_i = addr; c_rqst_byte_i = is_byte;
    c_hit_way_i = hway; c_lru_way_i = lway; c_miss_i = miss; c_buffer_hit_i = bhit;
    c_buffer_data_i = bdata; c_int_write_enable_i = 1; c_write_addr_i = wa; c_pc_i = pc;
  endtask

  task automatic drain(input logic [19:0] addr, input logic [31:0] data, input logic [1:0] way);
    sb_drain_valid_i = 1; sb_drain_addr_i = addr; sb_drain_data_i = data;
    sb_drain_byte_i = 0; sb_drain_way_i = way; sb_drain_hit_i = 1;
    #1;
    check("drain_ready", 32'(sb_drain_ready_o), 32'd1);
    tick();
    sb_drain_valid_i = 0; sb_drain_hit_i = 0;
  endtask

  // Runs a miss already driven this cycle until the FILL cycle; acks on the ack_at-th
  // request cycle and raises kill_i on the kill_at-th (0 = never).
  task automatic run_miss(input int ack_at, input int kill_at, input logic [127:0] line,
                          input logic [19:0] exp_addr, input logic [1:0] exp_way,
                          output int stalls);
    int reqs;
    bit done;
    reqs = 0;
    done = 0;
    stalls = stall_core_o ? 1 : 0;
    for (int n = 0; n < 30 && !done; n++) begin
      tick();
      mem_ack_i = 0;
      kill_i = 0;
      if (fill_valid_o) begin
        done = 1;
        check("fill_way", 32'(fill_way_o), 32'(exp_way));
        check("fill_addr", 32'(fill_addr_o), 32'(exp_addr));
        check("fill_stall_low", 32'(stall_core_o), 32'd0);
        clear_c();
      end else begin
        if (stall_core_o) stalls++;
        if (wb_valid_o) check("stall_no_wb", 32'(wb_valid_o), 32'd0);
        if (mem_rd_req_o) begin
          reqs++;
          if (reqs == 1) check("req_addr", 32'(mem_addr_o), 32'(exp_addr));
        end
        if (reqs == kill_at) kill_i = 1;
        if (reqs == ack_at) begin
          mem_ack_i = 1;
          mem_data_i = line;
        end
      end
    end
    if (!done) check("fill_timeout", 32'd0, 32'd1);
    mem_ack_i = 0;
    kill_i = 0;
  endtask

  initial begin
    int stalls;
    rst_i = 1; kill_i = 0; mem_ack_i = 0; mem_data_i = '0;
    sb_drain_valid_i = 0; sb_drain_addr_i = '0; sb_drain_data_i = '0;
    sb_drain_byte_i = 0; sb_drain_way_i = '0; sb_drain_hit_i = 0;
    clear_c();
    tick();
    tick();
    check("rst_wb_valid", 32'(wb_valid_o), 32'd0);
    check("rst_wb_data", wb_data_o, 32'd0);
    check("rst_stall", 32'(stall_core_o), 32'd0);
    check("rst_mem_req", 32'(mem_rd_req_o), 32'd0);
    check("rst_mem_addr", 32'(mem_addr_o), 32'd0);
    check("rst_fill", 32'(fill_valid_o), 32'd0);
    check("rst_drain_ready", 32'(sb_drain_ready_o), 32'd0);
    rst_i = 0;

    // 1: drain then word hit, one-cycle latency
    drain(20'h00014, 32'hDEADBEEF, 2'd2);
    drive_load(20'h00014, 0, 2'd2, 2'd0, 0, 0, '0, 5'd5, 32'h100);
    exp_q.push_back('{32'hDEADBEEF, 1'b1, 5'd5, 32'h100});
    #1;
    check("t1_stall", 32'(stall_core_o), 32'd0);
    tick();
    check("t1_latency", 32'(wb_valid_o), 32'd1);

    // 2: byte load of byte 2 of the same word
    drive_load(20'h00016, 1, 2'd2, 2'd0, 0, 0, '0, 5'd6, 32'h104);
    exp_q.push_back('{32'h000000AD, 1'b1, 5'd6, 32'h104});
    tick();
    clear_c();

    // 3: miss, ack on the third request cycle
    drive_load(20'h12340, 0, 2'd0, 2'd1, 1, 0, '0, 5'd7, 32'h108);
    exp_q.push_back('{32'h11223344, 1'b1, 5'd7, 32'h108});
    #1;
    check("t3_drain_block", 32'(sb_drain_ready_o), 32'd0);
    run_miss(3, 0, {32'h44444444, 32'h33333333, 32'h22222222, 32'h11223344},
             20'h12340, 2'd1, stalls);
    check("t3_stall_cycles", 32'(stalls), 32'd4);
    tick();
    check("t3_fill_once", 32'(fill_valid_o), 32'd0);
    check("t3_wb_after_fill", 32'(wb_valid_o), 32'd1);

    // 4: buffer forward overrides a tag miss
    drive_load(20'h22220, 0, 2'd0, 2'd3, 1, 1, 32'hCAFEF00D, 5'd8, 32'h10C);
    exp_q.push_back('{32'hCAFEF00D, 1'b1, 5'd8, 32'h10C});
    #1;
    check("t4_stall", 32'(stall_core_o), 32'd0);
    tick();
    clear_c();
    check("t4_no_req", 32'(mem_rd_req_o), 32'd0);

    // 4b: killed hit never retires
    drive_load(20'h00014, 0, 2'd2, 2'd0, 0, 0, '0, 5'd3, 32'h110);
    kill_i = 1;
    tick();
    kill_i = 0;
    clear_c();
    check("t4b_killed_wb", 32'(wb_valid_o), 32'd0);

    // 5: kill during REQ still fills the line, no retire
    drive_load(20'h00A24, 0, 2'd0, 2'd3, 1, 0, '0, 5'd10, 32'h114);
    #1;
    run_miss(3, 2, {32'hD4D4D4D4, 32'hC3C3C3C3, 32'h5A5A1234, 32'hA1A1A1A1},
             20'h00A20, 2'd3, stalls);
    tick();
    check("t5_no_wb", 32'(wb_valid_o), 32'd0);
    drive_load(20'h00A24, 0, 2'd3, 2'd0, 0, 0, '0, 5'd11, 32'h118);
    exp_q.push_back('{32'h5A5A1234, 1'b1, 5'd11, 32'h118});
    tick();
    clear_c();

    // 6: reset while in REQ drops the refill; a stray ack is ignored
    drain(20'h00130, 32'h600DCAFE, 2'd0);
    drive_load(20'h00130, 0, 2'd0, 2'd0, 1, 0, '0, 5'd9, 32'h200);
    tick();
    check("t6_in_req", 32'(mem_rd_req_o), 32'd1);
    clear_c();
    rst_i = 1;
    tick();
    rst_i = 0;
    check("t6_rst_req", 32'(mem_rd_req_o), 32'd0);
    check("t6_rst_stall", 32'(stall_core_o), 32'd0);
    check("t6_rst_fill", 32'(fill_valid_o), 32'd0);
    mem_ack_i = 1;
    mem_data_i = {128{1'b1}};
    tick();
    mem_ack_i = 0;
    check("t6_ack_fill", 32'(fill_valid_o), 32'd0);
    check("t6_ack_req", 32'(mem_rd_req_o), 32'd0);
    check("t6_ack_stall", 32'(stall_core_o), 32'd0);
    drive_load(20'h00130, 0, 2'd0, 2'd0, 0, 0, '0, 5'd12, 32'h204);
    exp_q.push_back('{32'h600DCAFE, 1'b1, 5'd12, 32'h204});
    tick();
    clear_c();

    repeat (3) tick();
    check("scoreboard_drained", 32'(exp_q.size()), 32'd0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/c_cache_data_stage.md
Name: c_cache_data_stage

Overview:
- C (cache) stage of the pipeline; consumes the TL→C latch outputs.
- Holds the 4-way data array and selects load data: store-buffer forward, array hit, or refill after a miss.
- Runs the miss refill FSM against memory, stalls the core during a miss, and drives the registered C→WB interface.
- Cache is write-through, so there is no dirty eviction. Stores reach the array only via the store-buffer drain port.

Parameters:
- ADDR_W, 20, byte address width; offset = [3:0], index = [5:4], tag = [19:6].
- WAYS, 4, associativity; fixed 2-bit way encoding.
- SETS, 4, sets per way.
- LINE_W, 128, line width in bits (4 words).

Ports:
- clk_i  in  1  clock
- rst_i  in  1  reset; synchronous, active-high
- kill_i  in  1  flush current C-stage instruction
- c_valid_i  in  1  C-stage slot holds an instruction
- c_mem_read_i  in  1  instruction is a load
- c_addr_i  in  20  load byte address
- c_rqst_byte_i  in  1  1 = byte load, 0 = word load
- c_hit_way_i  in  2  hitting way from TL
- c_lru_way_i  in  2  refill victim way
- c_miss_i  in  1  tag miss
- c_buffer_hit_i  in  1  store-buffer forward valid
- c_buffer_data_i  in  32  store-buffer forwarded word/byte
- c_int_write_enable_i  in  1  register-file write
- c_write_addr_i  in  5  destination register
- c_pc_i  in  32  PC
- sb_drain_valid_i  in  1  store-buffer drain request
- sb_drain_addr_i  in  20  drain address
- sb_drain_data_i  in  32  drain data
- sb_drain_byte_i  in  1  byte store
- sb_drain_way_i  in  2  hit way of the drained store
- sb_drain_hit_i  in  1  drained store hits in cache
- sb_drain_ready_o  out  1  drain accepted this cycle
- mem_rd_req_o  out  1  line read request
- mem_addr_o  out  20  line-aligned address ([3:0] = 0)
- mem_ack_i  in  1  memory data valid
- mem_data_i  in  128  refill line
- fill_valid_o  out  1  one-cycle pulse; tag array installs line
- fill_way_o  out  2  way being filled
- fill_addr_o  out  20  line-aligned fill address
- stall_core_o  out  1  freeze upstream stages
- wb_valid_o  out  1  WB slot valid
- wb_data_o  out  32  load result
- wb_int_write_enable_o  out  1  register-file write enable
- wb_write_addr_o  out  5  destination register
- wb_pc_o  out  32  PC

Behaviour:
- Reset: FSM = IDLE; all outputs 0; data array contents undefined (tag valid bits live in TL).
- Reset mid-miss: drop the request, return to IDLE, write nothing to the array.
- Load data selection, priority order:
  - c_buffer_hit_i → c_buffer_data_i.
  - Else hit → word c_addr_i[3:2] of line {c_hit_way_i, c_addr_i[5:4]}.
  - Byte load: byte c_addr_i[1:0] of that word, zero-extended; little-endian.
- Hit or buffer hit: WB registers load next posedge (1-cycle latency). Non-load valid instructions pass control fields with wb_data_o = 0.
- Miss = c_valid_i & c_mem_read_i & c_miss_i & !c_buffer_hit_i.
- FSM IDLE: on miss, go to REQ. stall_core_o is asserted combinationally in that same cycle. Latch addr, lru_way and control fields.
- FSM REQ:
  - mem_rd_req_o = 1 and mem_addr_o = {addr[19:4], 4'b0}, both held stable until mem_ack_i.
  - On mem_ack_i: write mem_data_i into {lru_way, index} and go to FILL.
- FSM FILL, one cycle:
  - fill_valid_o = 1; fill_way_o and fill_addr_o driven.
  - Select load data from the captured line.
  - WB registers at the end of this cycle; stall_core_o deasserts in this cycle; go to IDLE.
- Miss latency: stall_core_o high from the miss cycle through the cycle before FILL. Total = 2 + memory wait cycles.
- While stall_core_o = 1 and not in FILL: wb_valid_o = 0, so no duplicate retire.
- kill_i in IDLE: the current instruction does not register; wb_valid_o = 0 next cycle.
- kill_i during REQ: refill completes and the line is still written with fill_valid_o pulsed; the WB write is suppressed (wb_valid_o = 0 after FILL).
- Drain port:
  - sb_drain_ready_o = sb_drain_valid_i & FSM == IDLE & !miss-this-cycle.
  - On accept with sb_drain_hit_i: merge word or byte into {sb_drain_way_i, sb_drain_addr_i[5:4]}. A drain miss is accepted and discarded (write-through).
- Same-cycle drain and load to the same line: the load reads pre-write data. The store buffer guarantees forwarding via c_buffer_hit_i.
- mem_ack_i outside REQ is ignored.

Test Plan:
1. Reset, then drain word 0xDEADBEEF to addr 0x00014, way 2 (hit), then load word 0x00014, hit_way 2 → wb_data_o = 0xDEADBEEF one cycle after C; stall_core_o stays 0.
2. Byte load 0x00016 after step 1 → wb_data_o = 0x000000AD.
3. Miss on 0x12340, lru_way 1; mem_ack_i 3 cycles after the request with word0 = 0x11223344:
   - mem_addr_o = 0x12340.
   - stall_core_o high 4 cycles.
   - fill_valid_o pulses once with way 1.
   - wb_data_o = 0x11223344.
4. Load with c_buffer_hit_i = 1, data 0xCAFEF00D, c_miss_i = 1 → no mem_rd_req_o; wb_data_o = 0xCAFEF00D.
5. kill_i during REQ → line is still filled and a later hit returns it; wb_valid_o is never asserted for the killed load.
6. rst_i asserted while in REQ → next cycle mem_rd_req_o = 0, stall_core_o = 0, FSM IDLE; a subsequent mem_ack_i is ignored.
